io_tx_sequencer: RTL and testbench

IO_TX_SEQUENCER -- requirements
Module: io_tx_sequencer

---
 rtl/io_tx_sequencer_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/io_tx_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_io_tx_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_tx_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// io_tx_sequencer_pkg
//
// Shared IO-bus definitions.  The IO block that decodes the register map and
// the sequencer that drives it import this package, so both sides agree on:
//   - the sequencer state encoding (tx_state_t)
//   - the default register addresses of the UART data/send register and the
//     status register
//   - the position of the UART busy flag inside the status word
//   - the layout of a word written to the UART register (uart_word)
// ---------------------------------------------------------------------------
package io_tx_sequencer_pkg;

    // Register map of the IO block.
    localparam logic [13:0] IO_ADDR_UART   = 14'd6;
    localparam logic [13:0] IO_ADDR_STATUS = 14'd9;

    // Bit index of uart_busy inside the status register.
    localparam int UART_BUSY_BIT = 1;

    // Sequencer states.  The bus strobes are decoded from these directly.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WR_SEND = 3'd2,
        POLL_HI = 3'd3,
        WR_CLR  = 3'd4,
        POLL_LO = 3'd5
    } tx_state_t;

    // A write to the UART register carries the byte in [7:0] and the send
    // trigger in bit 8.  Writing with send=1 starts the UART; writing the
    // same byte again with send=0 releases the trigger.
    function automatic logic [15:0] uart_word(input logic send, input logic [7:0] data);
        return {7'b0, send, data};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Byte-wide single-clock FIFO with DEPTH entries (DEPTH a power of two).
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst        in   asynchronous active-low reset, empties the FIFO
//   push       in   write push_data (ignored while full)
//   push_data  in   8-bit data to store
//   pop        in   discard the head entry (ignored while empty)
//   head       out  8-bit data at the head of the FIFO (valid when !empty)
//   level      out  number of stored entries, 0..DEPTH
//   full       out  level == DEPTH
//   empty      out  level == 0
//
// A push and a pop in the same cycle both take effect and leave the level
// unchanged.  Pointers are exactly log2(DEPTH) bits so they wrap modulo DEPTH
// on their own.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_LEVEL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == DEPTH_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/io_tx_sequencer.sv
// ---------------------------------------------------------------------------
// io_tx_sequencer
//
// Buffers bytes in a FIFO and hands each one to the UART through the shared
// IO bus.  For every byte the sequencer:
//   1. requests the bus and waits for the grant,
//   2. writes the byte with the send bit set to the UART register,
//   3. polls the status register until uart_busy rises (or gives up after
//      TIMEOUT cycles and flags timeout_err),
//   4. writes the byte again with the send bit cleared,
//   5. polls until uart_busy falls, then releases the bus.
//
// Parameters
//   DEPTH        FIFO depth in bytes (power of two, 2..16)
//   TIMEOUT      max cycles to wait for uart_busy to rise
//   ADDR_UART    UART data/send register address
//   ADDR_STATUS  status register address (bit 1 = uart_busy)
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst          in   asynchronous active-low reset
//   enable       in   allows a new byte transaction to start
//   push         in   write push_data into the FIFO
//   push_data    in   byte to transmit
//   full         out  FIFO holds DEPTH bytes
//   level        out  FIFO occupancy
//   bus_req      out  IO bus ownership request
//   bus_gnt      in   IO bus grant (held once given)
//   io_cs        out  IO chip select
//   io_write     out  IO write strobe
//   io_read      out  IO read strobe
//   io_adresse   out  IO register address (0 when the bus is unused)
//   io_dataout   out  IO write data (0 when not writing)
//   io_datain    in   IO read data
//   overflow     out  sticky: a push arrived while the FIFO was full
//   timeout_err  out  sticky: uart_busy never rose within TIMEOUT cycles
//   clr_err      in   clears both sticky flags (a new set event wins)
// ---------------------------------------------------------------------------
module io_tx_sequencer
    import io_tx_sequencer_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          TIMEOUT     = 1024,
    parameter logic [13:0] ADDR_UART   = IO_ADDR_UART,
    parameter logic [13:0] ADDR_STATUS = IO_ADDR_STATUS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        push,
    input  logic [7:0]  push_data,
    output logic        full,
    output logic [4:0]  level,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        io_cs,
    output logic        io_write,
    output logic        io_read,
    output logic [13:0] io_adresse,
    output logic [15:0] io_dataout,
    input  logic [15:0] io_datain,
    output logic        overflow,
    output logic        timeout_err,
    input  logic        clr_err
);

    // Poll counter is ceil(log2(TIMEOUT)) bits, at least one bit.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [7:0]            tx_byte;
    logic [CW-1:0]         poll_cnt;

    logic [$clog2(DEPTH):0] fifo_level;
    logic [7:0]             fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    logic uart_busy;
    logic poll_expired;
    logic overflow_set;
    logic timeout_set;
    logic datain_unused;

    sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign full  = fifo_full;
    assign level = 5'(fifo_level);

    // The byte leaves the FIFO at the end of the send write; the clear write
    // reuses the copy held in tx_byte.
    assign fifo_pop = (state == WR_SEND);

    assign uart_busy    = io_datain[UART_BUSY_BIT];
    assign poll_expired = (poll_cnt == CNT_LAST);

    // Only the busy flag of the status word matters to the sequencer.
    assign datain_unused = ^{io_datain[15:UART_BUSY_BIT+1], io_datain[UART_BUSY_BIT-1:0]};

    assign overflow_set = push && fifo_full;
    assign timeout_set  = (state == POLL_HI) && !uart_busy && poll_expired;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore-decoded bus outputs.  Every output drops to
    // zero outside the states that actually use the bus.
    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        io_cs      = 1'b0;
        io_write   = 1'b0;
        io_read    = 1'b0;
        io_adresse = '0;
        io_dataout = '0;

        case (state)
            IDLE: begin
                if (!fifo_empty && enable) begin
                    state_next = REQ;
                end
            end

            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_next = WR_SEND;
                end
            end

            WR_SEND: begin
                bus_req    = 1'b1;
                io_cs      = 1'b1;
                io_write   = 1'b1;
                io_adresse = ADDR_UART;
                io_dataout = uart_word(1'b1, tx_byte);
                state_next = POLL_HI;
            end

            POLL_HI: begin
                bus_req    = 1'b1;
                io_cs      = 1'b1;
                io_read    = 1'b1;
                io_adresse = ADDR_STATUS;
                if (uart_busy || poll_expired) begin
                    state_next = WR_CLR;
                end
            end

            WR_CLR: begin
                bus_req    = 1'b1;
                io_cs      = 1'b1;
                io_write   = 1'b1;
                io_adresse = ADDR_UART;
                io_dataout = uart_word(1'b0, tx_byte);
                state_next = POLL_LO;
            end

            POLL_LO: begin
                bus_req    = 1'b1;
                io_cs      = 1'b1;
                io_read    = 1'b1;
                io_adresse = ADDR_STATUS;
                if (!uart_busy) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the head byte as the grant arrives so that both UART writes
    // carry the same value even though the FIFO pops after the first one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_byte <= '0;
        end else if ((state == REQ) && bus_gnt) begin
            tx_byte <= fifo_head;
        end
    end

    // Poll counter runs only while waiting for busy to rise and sits at zero
    // everywhere else, so every entry into POLL_HI starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt <= '0;
        end else if (state == POLL_HI) begin
            poll_cnt <= poll_cnt + CW'(1);
        end else begin
            poll_cnt <= '0;
        end
    end

    // Sticky error flags; a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            if (timeout_set) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_io_tx_sequencer
//
// Every accepted byte is expected to appear on the IO bus as two UART
// writes: {addr 6, 0x0100 | byte} followed by {addr 6, byte}.  The stimulus
// side appends these pairs to exp_q when it pushes a byte it knows will be
// accepted; the monitor pops and compares on every observed bus write.
// A small model of the IO block raises/lowers uart_busy after each send.
// ---------------------------------------------------------------------------
module tb_io_tx_sequencer;

    localparam int          DEPTH    = 8;
    localparam int          TIMEOUT  = 40;
    localparam int          WAIT_MAX = 600;
    localparam logic [13:0] A_UART   = 14'd6;
    localparam logic [13:0] A_STATUS = 14'd9;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        push;
    logic [7:0]  push_data;
    logic        full;
    logic [4:0]  level;
    logic        bus_req;
    logic        bus_gnt;
    logic        io_cs;
    logic        io_write;
    logic        io_read;
    logic [13:0] io_adresse;
    logic [15:0] io_dataout;
    logic [15:0] io_datain;
    logic        overflow;
    logic        timeout_err;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    logic [29:0] exp_q[$];
    int          runs[$];

    // IO block model controls
    int   rise_delay;
    int   fall_delay;
    bit   never_busy;
    logic busy;
    int   io_phase;
    int   io_dly;

    io_tx_sequencer #(
        .DEPTH       (DEPTH),
        .TIMEOUT     (TIMEOUT),
        .ADDR_UART   (A_UART),
        .ADDR_STATUS (A_STATUS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .push        (push),
        .push_data   (push_data),
        .full        (full),
        .level       (level),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .io_cs       (io_cs),
        .io_write    (io_write),
        .io_read     (io_read),
        .io_adresse  (io_adresse),
        .io_dataout  (io_dataout),
        .io_datain   (io_datain),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status word: busy on bit 1, the other bits are filled with junk.
    assign io_datain = {14'h1A5, busy, 1'b1};

    // IO block model: busy rises rise_delay cycles after a send write and
    // falls fall_delay cycles after that.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            io_phase <= 0;
            io_dly   <= 0;
        end else begin
            case (io_phase)
                0: begin
                    if (io_cs && io_write && io_dataout[8] && !never_busy) begin
                        io_dly   <= rise_delay;
                        io_phase <= 1;
                    end
                end
                1: begin
                    if (io_dly <= 1) begin
                        busy     <= 1'b1;
                        io_dly   <= fall_delay;
                        io_phase <= 2;
                    end else begin
                        io_dly <= io_dly - 1;
                    end
                end
                default: begin
                    if (io_dly <= 1) begin
                        busy     <= 1'b0;
                        io_phase <= 0;
                    end else begin
                        io_dly <= io_dly - 1;
                    end
                end
            endcase
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired, got no event, required one within %0d cycles", name, WAIT_MAX);
    endtask

    function automatic logic [31:0] status_vec();
        return {20'b0, bus_req, io_cs, io_write, io_read, full, overflow, timeout_err, level};
    endfunction

    function automatic logic [31:0] bus_vec();
        return {2'b0, io_adresse, io_dataout};
    endfunction

    // Push one byte across one rising edge; called and returns at a negedge.
    task automatic apply_stimulus(input logic [7:0] b, input bit accepted);
        push      = 1'b1;
        push_data = b;
        if (accepted) begin
            exp_q.push_back({A_UART, 16'h0100 | {8'h00, b}});
            exp_q.push_back({A_UART, {8'h00, b}});
        end
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic wait_write(input logic send_bit, input string name);
        bit found;
        found = 1'b0;
        for (int n = 0; n < WAIT_MAX && !found; n++) begin
            @(negedge clk);
            found = io_cs && io_write && (io_dataout[8] == send_bit);
        end
        if (!found) report_timeout(name);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < WAIT_MAX && !done; n++) begin
            @(negedge clk);
            done = (level == 5'd0) && !bus_req && (exp_q.size() == 0);
        end
        if (!done) report_timeout(name);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (io_cs && io_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h, required no write",
                             io_adresse, io_dataout);
                end else begin
                    logic [29:0] e;
                    e = exp_q.pop_front();
                    check_output("bus_write", bus_vec(), {2'b0, e});
                end
            end else if (io_cs && io_read) begin
                check_output("status_read", bus_vec(), {2'b0, A_STATUS, 16'h0000});
            end else if (!io_cs) begin
                check_output("idle_bus", {io_write, io_read, io_adresse, io_dataout}, 32'h0);
            end
        end
    end

    initial begin
        int          polls;
        bit          seen_high;
        int          low_run;
        bit          done;
        int          k;
        int          extra;

        rst        = 1'b0;
        enable     = 1'b0;
        push       = 1'b0;
        push_data  = 8'h00;
        bus_gnt    = 1'b0;
        clr_err    = 1'b0;
        rise_delay = 3;
        fall_delay = 20;
        never_busy = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset_status", status_vec(), 32'h0);
        check_output("reset_bus", bus_vec(), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check_output("post_reset_status", status_vec(), 32'h0);

        // Single byte 0x41 and start latency
        enable  = 1'b1;
        bus_gnt = 1'b1;
        apply_stimulus(8'h41, 1'b1);
        check_output("lat_level", 32'(level), 32'd1);
        check_output("lat_idle", 32'(bus_req), 32'd0);
        @(negedge clk);
        check_output("lat_req", 32'({bus_req, io_cs}), 32'(2'b10));
        @(negedge clk);
        check_output("lat_send", 32'({io_cs, io_write, io_adresse}), 32'({1'b1, 1'b1, A_UART}));
        wait_idle("single_drain");
        check_output("single_level", 32'(level), 32'd0);

        // Fill past DEPTH with enable low
        enable = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            apply_stimulus(8'hB0 + 8'(i), i < DEPTH);
        end
        check_output("fill_status", status_vec(), {20'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd8});
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_output("overflow_clr", 32'(overflow), 32'd0);
        enable = 1'b1;
        wait_idle("fill_drain");

        // Grant withheld for 50 cycles
        bus_gnt = 1'b0;
        apply_stimulus(8'h5A, 1'b1);
        @(negedge clk);
        for (int c = 0; c < 50; c++) begin
            check_output("gnt_wait", 32'({bus_req, io_cs}), 32'(2'b10));
            @(negedge clk);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        check_output("gnt_start", 32'({io_cs, io_write, io_dataout[8]}), 32'(3'b111));
        wait_idle("gnt_drain");

        // Three bytes back to back, bus_req gaps of one cycle
        apply_stimulus(8'h10, 1'b1);
        apply_stimulus(8'h20, 1'b1);
        apply_stimulus(8'h30, 1'b1);
        seen_high = 1'b0;
        low_run   = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus_req) begin
                if (seen_high && low_run > 0) runs.push_back(low_run);
                seen_high = 1'b1;
                low_run   = 0;
            end else if (seen_high) begin
                low_run++;
            end
        end
        check_output("gap_count", 32'(runs.size()), 32'd2);
        if (runs.size() == 2) begin
            check_output("gap0_len", 32'(runs[0]), 32'd1);
            check_output("gap1_len", 32'(runs[1]), 32'd1);
        end
        wait_idle("three_drain");

        // enable dropped mid-transaction
        apply_stimulus(8'h61, 1'b1);
        apply_stimulus(8'h62, 1'b1);
        wait_write(1'b1, "en_send");
        enable = 1'b0;
        done = 1'b0;
        for (int n = 0; n < WAIT_MAX && !done; n++) begin
            @(negedge clk);
            done = !bus_req;
        end
        if (!done) report_timeout("en_finish");
        repeat (10) @(negedge clk);
        check_output("en_hold", 32'({bus_req, level}), 32'({1'b0, 5'd1}));
        enable = 1'b1;
        wait_idle("en_drain");

        // Busy never rises: timeout
        never_busy = 1'b1;
        apply_stimulus(8'h77, 1'b1);
        wait_write(1'b1, "to_send");
        polls = 0;
        done  = 1'b0;
        for (int n = 0; n < TIMEOUT + 20 && !done; n++) begin
            @(negedge clk);
            if (io_cs && io_read) polls++;
            else done = 1'b1;
        end
        check_output("to_clr_write", 32'({io_cs, io_write, io_dataout[8]}), 32'(3'b110));
        check_output("to_poll_cycles", 32'(polls), 32'(TIMEOUT));
        check_output("to_flag", 32'(timeout_err), 32'd1);
        wait_idle("to_drain");
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_output("to_flag_clr", 32'(timeout_err), 32'd0);
        never_busy = 1'b0;

        // Randomized bursts
        for (int b = 0; b < 6; b++) begin
            rise_delay = $urandom_range(1, 10);
            fall_delay = $urandom_range(1, 15);
            enable  = 1'b0;
            bus_gnt = 1'b0;
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
            k = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < k; i++) begin
                apply_stimulus(8'($urandom), i < DEPTH);
            end
            check_output("burst_status", status_vec(),
                         {20'b0, 4'b0000, 1'(k >= DEPTH), 1'(k > DEPTH), 1'b0,
                          5'((k > DEPTH) ? DEPTH : k)});
            enable = 1'b1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            bus_gnt = 1'b1;
            extra = 0;
            done  = 1'b0;
            for (int c = 0; c < 3000 && !done; c++) begin
                if (extra < 3 && level != 5'd0 && level <= 5'(DEPTH - 2) && $urandom_range(0, 7) == 0) begin
                    apply_stimulus(8'($urandom), 1'b1);
                    extra++;
                end else begin
                    @(negedge clk);
                end
                done = (level == 5'd0) && !bus_req && (exp_q.size() == 0);
            end
            if (!done) report_timeout("burst_drain");
        end

        // Reset during POLL_LO
        rise_delay = 3;
        fall_delay = 20;
        apply_stimulus(8'h81, 1'b1);
        apply_stimulus(8'h82, 1'b1);
        wait_write(1'b0, "rst_clr_write");
        @(negedge clk);
        check_output("rst_in_poll_lo", 32'({io_cs, io_read, busy}), 32'(3'b111));
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_output("rst_status", status_vec(), 32'h0);
        check_output("rst_bus", bus_vec(), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_release", status_vec(), 32'h0);
        apply_stimulus(8'h99, 1'b1);
        wait_idle("rst_after_drain");

        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
